// File: rtl/seg7_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_rx
//  Description : Receive-side monitor for a two-digit multiplexed 7-segment
//                display bus. Filters scan transitions with a run-length
//                stability check, reverse-decodes each stable segment pattern
//                to its hex value and holds one result register per digit.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STABLE        consecutive identical samples needed to commit (1..255)
//  Ports
//    clk           system clock, rising edge
//    rst           synchronous active-high reset
//    scan_select   [1:0] active-low digit enables (10=dig0, 01=dig1,
//                  11=idle, 00=conflict)
//    seg7          [7:0] segment lines, bit7=dp, bits6..0=a..g
//    err_clr       pulse, clears dig_bad and sel_conflict
//    dig0_num      [3:0] last committed hex value of digit 0
//    dig1_num      [3:0] last committed hex value of digit 1
//    dig_vld       [1:0] last commit per digit was a legal glyph
//    dig_dp        [1:0] dp captured at last commit per digit
//    dig_upd       [1:0] one-cycle pulse on each commit
//    dig_bad       [1:0] sticky, illegal pattern committed
//    sel_conflict  sticky, scan_select==00 sampled
// ============================================================================
module seg7_scan_rx #(
    parameter int STABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] scan_select,
    input  logic [7:0] seg7,
    input  logic       err_clr,
    output logic [3:0] dig0_num,
    output logic [3:0] dig1_num,
    output logic [1:0] dig_vld,
    output logic [1:0] dig_dp,
    output logic [1:0] dig_upd,
    output logic [1:0] dig_bad,
    output logic       sel_conflict
);

    localparam logic [7:0] c_stable   = 8'(STABLE);
    localparam logic [1:0] c_sel_dig0 = 2'b10;
    localparam logic [1:0] c_sel_dig1 = 2'b01;
    localparam logic [1:0] c_sel_none = 2'b11;
    localparam logic [1:0] c_sel_bad  = 2'b00;

    // Returns {legal, blank, value}; dp is deliberately excluded.
    function automatic logic [5:0] f_decode(input logic [6:0] pat);
        logic [5:0] res;
        res = 6'b00_0000;
        case (pat)
            7'h7E: res = {2'b10, 4'h0};
            7'h30: res = {2'b10, 4'h1};
            7'h6D: res = {2'b10, 4'h2};
            7'h79: res = {2'b10, 4'h3};
            7'h33: res = {2'b10, 4'h4};
            7'h5B: res = {2'b10, 4'h5};
            7'h5F: res = {2'b10, 4'h6};
            7'h70: res = {2'b10, 4'h7};
            7'h7F: res = {2'b10, 4'h8};
            7'h7B: res = {2'b10, 4'h9};
            7'h77: res = {2'b10, 4'hA};
            7'h1F: res = {2'b10, 4'hB};
            7'h4E: res = {2'b10, 4'hC};
            7'h3D: res = {2'b10, 4'hD};
            7'h4F: res = {2'b10, 4'hE};
            7'h47: res = {2'b10, 4'hF};
            7'h00: res = {2'b01, 4'h0};
            default: res = 6'b00_0000;
        endcase
        return res;
    endfunction

    logic [1:0] r_last_sel;
    logic [7:0] r_last_pat;
    logic [7:0] r_cnt;

    logic       w_sel_ok;
    logic       w_same;
    logic       w_commit;
    logic       w_dig;
    logic [7:0] w_cnt_nxt;
    logic [5:0] w_dec;
    logic [1:0] w_bad_set;
    logic       w_conf_set;

    always_comb begin
        w_sel_ok   = (scan_select == c_sel_dig0) || (scan_select == c_sel_dig1);
        w_same     = (scan_select == r_last_sel) && (seg7 == r_last_pat);
        w_dig      = (scan_select == c_sel_dig1);
        w_dec      = f_decode(seg7[6:0]);
        w_conf_set = (scan_select == c_sel_bad);
        w_cnt_nxt  = 8'd0;
        w_commit   = 1'b0;
        if (w_sel_ok) begin
            if (w_same) begin
                // Saturated count means this run already committed.
                w_cnt_nxt = (r_cnt == c_stable) ? r_cnt : r_cnt + 8'd1;
                w_commit  = (r_cnt != c_stable) && ((r_cnt + 8'd1) == c_stable);
            end else begin
                w_cnt_nxt = 8'd1;
                w_commit  = (c_stable == 8'd1);
            end
        end
        w_bad_set = 2'b00;
        if (w_commit && !w_dec[5] && !w_dec[4]) begin
            w_bad_set = w_dig ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_sel   <= c_sel_none;
            r_last_pat   <= 8'h00;
            r_cnt        <= 8'd0;
            dig0_num     <= 4'h0;
            dig1_num     <= 4'h0;
            dig_vld      <= 2'b00;
            dig_dp       <= 2'b00;
            dig_upd      <= 2'b00;
            dig_bad      <= 2'b00;
            sel_conflict <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            dig_upd <= 2'b00;
            if (w_sel_ok && !w_same) begin
                r_last_sel <= scan_select;
                r_last_pat <= seg7;
            end
            if (w_commit) begin
                dig_upd[w_dig] <= 1'b1;
                dig_dp[w_dig]  <= seg7[7];
                dig_vld[w_dig] <= w_dec[5];
                if (w_dec[5]) begin
                    if (w_dig) begin
                        dig1_num <= w_dec[3:0];
                    end else begin
                        dig0_num <= w_dec[3:0];
                    end
                end
            end
            // A set event in the same cycle as err_clr wins.
            dig_bad      <= (dig_bad & ~{2{err_clr}}) | w_bad_set;
            sel_conflict <= (sel_conflict & ~err_clr) | w_conf_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_rx
//  Description : Self-checking bench for seg7_scan_rx. Directed scenarios
//                followed by random scan traffic, compared every cycle with a
//                run-length reference model of the display monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_rx;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] scan_select = 2'b11;
    logic [7:0] seg7 = 8'h00;
    logic       err_clr = 1'b0;
    logic [3:0] dig0_num;
    logic [3:0] dig1_num;
    logic [1:0] dig_vld;
    logic [1:0] dig_dp;
    logic [1:0] dig_upd;
    logic [1:0] dig_bad;
    logic       sel_conflict;

    seg7_scan_rx #(.STABLE(STABLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_select  (scan_select),
        .seg7         (seg7),
        .err_clr      (err_clr),
        .dig0_num     (dig0_num),
        .dig1_num     (dig1_num),
        .dig_vld      (dig_vld),
        .dig_dp       (dig_dp),
        .dig_upd      (dig_upd),
        .dig_bad      (dig_bad),
        .sel_conflict (sel_conflict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyphs [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: length of the current run of identical samples.
    int         m_run;
    logic [1:0] m_sel;
    logic [7:0] m_pat;
    logic [3:0] e_num [2];
    logic [1:0] e_vld, e_dp, e_upd, e_bad;
    logic       e_conf;

    function automatic int glyph_value(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_sel = 2'b11; m_pat = 8'h00;
        e_num[0] = 4'h0; e_num[1] = 4'h0;
        e_vld = 2'b00; e_dp = 2'b00; e_upd = 2'b00; e_bad = 2'b00; e_conf = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] s, input logic [7:0] p, input logic c);
        logic [1:0] bad_set;
        logic       conf_set;
        int         d;
        int         v;
        bad_set = 2'b00; conf_set = 1'b0; e_upd = 2'b00;
        if (s == 2'b10 || s == 2'b01) begin
            if (m_run > 0 && s == m_sel && p == m_pat) begin
                m_run++;
            end else begin
                m_sel = s; m_pat = p; m_run = 1;
            end
            if (m_run == STABLE) begin
                d = (s == 2'b10) ? 0 : 1;
                v = glyph_value(p[6:0]);
                e_upd[d] = 1'b1;
                e_dp[d]  = p[7];
                if (v >= 0) begin
                    e_num[d] = 4'(v);
                    e_vld[d] = 1'b1;
                end else begin
                    e_vld[d] = 1'b0;
                    if (p[6:0] != 7'h00) bad_set[d] = 1'b1;
                end
            end
        end else begin
            m_run = 0;
            if (s == 2'b00) conf_set = 1'b1;
        end
        if (c) begin
            e_bad = 2'b00; e_conf = 1'b0;
        end
        e_bad  = e_bad | bad_set;
        e_conf = e_conf | conf_set;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":dig0_num"}, {4'h0, dig0_num}, {4'h0, e_num[0]});
        chk({tag, ":dig1_num"}, {4'h0, dig1_num}, {4'h0, e_num[1]});
        chk({tag, ":dig_vld"}, {6'h0, dig_vld}, {6'h0, e_vld});
        chk({tag, ":dig_dp"}, {6'h0, dig_dp}, {6'h0, e_dp});
        chk({tag, ":dig_upd"}, {6'h0, dig_upd}, {6'h0, e_upd});
        chk({tag, ":dig_bad"}, {6'h0, dig_bad}, {6'h0, e_bad});
        chk({tag, ":sel_conflict"}, {7'h0, sel_conflict}, {7'h0, e_conf});
        chk({tag, ":upd_onehot0"}, {7'h0, $onehot0(dig_upd)}, 8'h01);
    endtask

    // One clock: drive at negedge, model and compare 1 time unit after posedge.
    task automatic step(input string tag, input logic [1:0] s, input logic [7:0] p,
                        input logic c, input logic r);
        @(negedge clk);
        scan_select = s; seg7 = p; err_clr = c; rst = r;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_step(s, p, c);
        check_all(tag);
    endtask

    task automatic hold(input string tag, input logic [1:0] s, input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) step(tag, s, p, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // Reset with random inputs: every output must be zero.
        for (int i = 0; i < 3; i++) begin
            step("reset", 2'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        // First commit of digit 0 after the 4th edge.
        hold("d0_first", 2'b10, 8'h7E, 3);
        chk("d0_no_early_upd", {6'h0, dig_upd}, 8'h00);
        hold("d0_first", 2'b10, 8'h7E, 1);
        chk("d0_upd_pulse", {6'h0, dig_upd}, 8'h01);
        chk("d0_vld", {6'h0, dig_vld}, 8'h01);
        hold("d0_hold", 2'b10, 8'h7E, 3);
        chk("d0_upd_once", {6'h0, dig_upd}, 8'h00);

        // Alternating scan, 8 cycles per dwell.
        for (int k = 0; k < 2; k++) begin
            hold("alt_d0", 2'b10, 8'h30, 8);
            hold("alt_d1", 2'b01, 8'hCF, 8);
        end
        chk("alt_num0", {4'h0, dig0_num}, 8'h01);
        chk("alt_num1", {4'h0, dig1_num}, 8'h0E);
        chk("alt_dp", {6'h0, dig_dp}, 8'h02);
        chk("alt_vld", {6'h0, dig_vld}, 8'h03);

        // Short dwell after reset: nothing may commit.
        step("rst2", 2'b11, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            hold("short_d0", 2'b10, 8'h6D, 3);
            hold("short_d1", 2'b01, 8'h33, 3);
        end
        chk("short_vld", {6'h0, dig_vld}, 8'h00);

        // Single-cycle glitch restarts the run; 9 never committed.
        hold("glitch", 2'b01, 8'h79, 2);
        hold("glitch", 2'b01, 8'h7B, 1);
        hold("glitch", 2'b01, 8'h79, 4);
        chk("glitch_num1", {4'h0, dig1_num}, 8'h03);

        // Illegal then blank on digit 0, then err_clr.
        hold("illegal", 2'b10, 8'h01, 4);
        chk("illegal_bad", {6'h0, dig_bad}, 8'h01);
        hold("blank", 2'b10, 8'h00, 4);
        step("errclr", 2'b11, 8'h00, 1'b1, 1'b0);
        chk("errclr_bad", {6'h0, dig_bad}, 8'h00);

        // Conflict, restart, and set-over-clear priority.
        hold("conf_pre", 2'b10, 8'h5B, 2);
        step("conflict", 2'b00, 8'h5B, 1'b0, 1'b0);
        chk("conflict_set", {7'h0, sel_conflict}, 8'h01);
        hold("conf_post", 2'b10, 8'h5B, 4);
        step("conf_clr", 2'b00, 8'h00, 1'b1, 1'b0);
        chk("conf_priority", {7'h0, sel_conflict}, 8'h01);
        step("conf_clr2", 2'b11, 8'h00, 1'b1, 1'b0);

        // Random scan traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] s;
            logic [7:0] p;
            int         pick;
            int         dwell;
            pick = int'($urandom_range(0, 15));
            s = (pick < 7) ? 2'b10 : (pick < 14) ? 2'b01 : (pick == 14) ? 2'b11 : 2'b00;
            pick = int'($urandom_range(0, 9));
            p[6:0] = (pick < 7) ? glyphs[$urandom_range(0, 15)] :
                     (pick == 7) ? 7'h00 : 7'($urandom);
            p[7] = 1'($urandom);
            dwell = int'($urandom_range(1, 7));
            for (int i = 0; i < dwell; i++) begin
                step("rand", s, p, ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 299) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receive-side monitor for the two-digit multiplexed 7-segment display bus. It samples the scan-select and segment lines produced by the display driver and filters out scan transitions. It reverse-decodes each stable segment pattern back to its 4-bit hex value and holds one result register per digit. It sits beside the display driver on the lab board and gives self-checking benches, and the LED/UART debug path, the digits actually shown.

## Interface
- STABLE, default 4: number of consecutive identical samples required before a digit is committed; legal range 1..255.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- scan_select  in  2  digit enables, active-low, one bit per digit:
  - 2'b10 selects digit 0.
  - 2'b01 selects digit 1.
  - 2'b11 selects no digit.
  - 2'b00 is a conflict.
- seg7  in  8  segment lines, active-high:
  - bit 7 = dp.
  - bits 6..0 = segments a,b,c,d,e,f,g.
- err_clr  in  1  single-cycle pulse; clears dig_bad and sel_conflict.
- dig0_num  out  4  last committed hex value of digit 0.
- dig1_num  out  4  last committed hex value of digit 1.
- dig_vld  out  2  per digit: the last commit was a legal hex glyph.
- dig_dp  out  2  per digit: dp state captured at the last commit.
- dig_upd  out  2  per digit: one-cycle pulse on every commit.
- dig_bad  out  2  per digit: sticky flag, an illegal pattern was committed.
- sel_conflict  out  1  sticky flag, scan_select==2'b00 was sampled.

## Operation
- **Glyph table (bits 6..0 → value):**
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
  - 00 → blank.
  - Every other pattern is illegal.
- **Stability filter registers:** last_sel (2), last_pat (8), cnt (8, saturating at STABLE).
- **Filter update, every edge:**
  - scan_select is 2'b10 or 2'b01, and the (scan_select, seg7) pair equals (last_sel, last_pat): cnt ← min(cnt+1, STABLE).
  - scan_select is 2'b10 or 2'b01, but the pair differs: last_sel/last_pat ← inputs, cnt ← 1.
  - scan_select is 2'b11: cnt ← 0, no commit.
  - scan_select is 2'b00: cnt ← 0, sel_conflict ← 1, no commit.
- **Commit:**
  - Happens on the edge at which cnt reaches STABLE, exactly once per run.
  - A run that holds longer does not re-commit.
  - For STABLE=1, the commit happens on the first sample of each new pair.
- **Commit action for digit N:**
  - dig_upd[N] ← 1 for one cycle.
  - dig_dp[N] ← seg7[7].
  - Legal glyph: digN_num ← value, dig_vld[N] ← 1.
  - Blank: dig_vld[N] ← 0, digN_num unchanged.
  - Illegal: dig_vld[N] ← 0, dig_bad[N] ← 1, digN_num unchanged.
- **dp handling:** dp takes no part in glyph decode. It does take part in the stability comparison, so a dp change restarts the run.
- **err_clr:** clears dig_bad and sel_conflict on the next edge. If it coincides with a new set event, the set wins.
- **Scope:** the block never drives the display bus; it is receive-only.

## Timing
- **Reset:** every output is 0, including dig0_num and dig1_num. Internal state resets to cnt=0, last_sel=2'b11, last_pat=0.
- **Reset mid-run:** rst overrides everything, including a commit due on the same edge.
- **Latency:** if a pair is first sampled at edge t, the outputs change after edge t+STABLE-1. dig_upd is high for the following cycle only.
- **Digit switching:** when the scan switches digits, the new digit needs a full STABLE run of its own.
  - With the driver dwelling D cycles per digit, commits occur only if D ≥ STABLE.
- **Glitch rejection:** a single-cycle glitch of the pair restarts the run. The glitch is never committed unless STABLE=1.
- **Independence:** the two digits update independently. At most one dig_upd bit is high in any cycle.

## Test plan
- **Reset:** assert rst with random inputs → all outputs 0. Release it, then hold scan_select=2'b10 and seg7=8'h7E for 4 cycles → dig0_num=0, dig_vld=2'b01, one-cycle dig_upd=2'b01 after the 4th edge.
- **Alternating scan:** alternate digit 0 = 8'h30 and digit 1 = 8'hCF (dp + E), 8 cycles each → dig0_num=1, dig1_num=E, dig_dp=2'b10, dig_vld=2'b11, and exactly one upd pulse per dwell.
- **Short dwell:** dwell of 3 cycles with STABLE=4 → no commits, all outputs stay at reset values.
- **Glitch:** digit 1 = 8'h79 for 2 cycles, 1 cycle of 8'h7B, then 8'h79 for 4 cycles → a single commit of 3, and 9 is never seen.
- **Illegal and blank:** illegal 8'h01 on digit 0 for 4 cycles → dig_bad=2'b01, dig_vld[0]=0, dig0_num unchanged. Then 8'h00 for 4 cycles → upd pulse, vld still 0. Then err_clr → dig_bad=0.
- **Conflict and clear priority:** scan_select=2'b00 for 1 cycle → sel_conflict=1 and the run restarts. err_clr on the same edge as a second 2'b00 → sel_conflict stays 1.
